pkt_ingress_wr: RTL and testbench

PKT_INGRESS_WR -- requirements
Module: pkt_ingress_wr

---
 rtl/pkt_ingress_wr.sv | 215 +++++++++++++++++++++
 tb/tb_pkt_ingress_wr.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_ingress_wr.sv
// Streaming packet ingress: writes each packet into a ring buffer as a
// reserved header slot followed by its data words, via a write master.
// Optional macro INGRESS_DROP_COUNT_EN enables the saturating drop counter.
`timescale 1ns/1ps

module pkt_ingress_wr #(
    parameter logic [31:0] RING_BASE     = 32'h0000_0000,
    parameter int          RING_WORDS    = 4096,
    parameter int          MAX_PKT_WORDS = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        asi_valid,
    input  logic [31:0] asi_data,
    input  logic        asi_sop,
    input  logic        asi_eop,
    input  logic [1:0]  asi_empty,
    output logic        asi_ready,
    output logic [31:0] avm_address,
    output logic [31:0] avm_writedata,
    output logic        avm_write,
    input  logic        avm_waitrequest,
    input  logic [31:0] rd_ptr,
    output logic [31:0] pkt_begin,
    output logic [31:0] pkt_end,
    output logic        pkt_done,
    output logic [15:0] drop_count
);

    localparam int          AW       = $clog2(RING_WORDS);
    localparam int          CW       = $clog2(MAX_PKT_WORDS + 1);
    localparam logic [31:0] IDX_MASK = 32'(RING_WORDS - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DATA    = 3'd1;
    localparam logic [2:0] S_DISCARD = 3'd2;
    localparam logic [2:0] S_HDR     = 3'd3;
    localparam logic [2:0] S_DROP    = 3'd4;

    logic [2:0]    r_state;
    logic [AW-1:0] r_wptr;
    logic [CW-1:0] r_count;
    logic          r_trunc;
    logic [1:0]    r_empty;
    logic          r_hdr_sent;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic          r_write;
    logic [31:0]   r_pkt_begin;
    logic [31:0]   r_pkt_end;
    logic          r_pkt_done;

    logic [31:0]   w_used;
    logic [31:0]   w_free;
    logic          w_room;
    logic          w_wr_done;
    logic          w_wr_free;
    logic          w_ready_state;
    logic          w_beat;
    logic          w_last_beat;
    logic [31:0]   w_data_addr;
    logic [31:0]   w_hdr_addr;
    logic [31:0]   w_last_addr;
    logic [31:0]   w_hdr_word;

    function automatic logic [31:0] f_addr(input logic [31:0] idx);
        return RING_BASE + ((idx & IDX_MASK) << 2);
    endfunction

    // Occupancy is measured from the header slot, so a reserved but
    // unfinished packet is never considered free space.
    assign w_used    = (32'(r_wptr) - rd_ptr) & IDX_MASK;
    assign w_free    = 32'(RING_WORDS - 1) - w_used;
    assign w_room    = (w_free >= 32'(MAX_PKT_WORDS + 1));

    assign w_wr_done = r_write & ~avm_waitrequest;
    assign w_wr_free = ~r_write | ~avm_waitrequest;

    always_comb begin
        w_ready_state = 1'b0;
        case (r_state)
            S_IDLE, S_DISCARD, S_DROP: w_ready_state = 1'b1;
            S_DATA:                    w_ready_state = w_wr_free;
            default:                   w_ready_state = 1'b0;
        endcase
    end

    assign asi_ready   = w_ready_state & ~reset;
    assign w_beat      = asi_valid & asi_ready;
    assign w_last_beat = (32'(r_count) + 32'd1 == 32'(MAX_PKT_WORDS));

    assign w_data_addr = f_addr(32'(r_wptr) + 32'd1 + 32'(r_count));
    assign w_hdr_addr  = f_addr(32'(r_wptr));
    assign w_last_addr = f_addr(32'(r_wptr) + 32'(r_count));
    // asi_empty only applies when the packet really ended on its eop beat.
    assign w_hdr_word  = {r_trunc, 15'b0,
                          16'((32'(r_count) << 2) - (r_trunc ? 32'd0 : {30'd0, r_empty}))};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wptr      <= '0;
            r_count     <= '0;
            r_trunc     <= 1'b0;
            r_empty     <= 2'b0;
            r_hdr_sent  <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_write     <= 1'b0;
            r_pkt_begin <= 32'd0;
            r_pkt_end   <= 32'd0;
            r_pkt_done  <= 1'b0;
        end else begin
            r_pkt_done <= 1'b0;
            if (w_wr_done) begin
                r_write <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_beat && asi_sop) begin
                        if (enable && w_room) begin
                            r_addr     <= f_addr(32'(r_wptr) + 32'd1);
                            r_wdata    <= asi_data;
                            r_write    <= 1'b1;
                            r_count    <= CW'(1);
                            r_trunc    <= 1'b0;
                            r_hdr_sent <= 1'b0;
                            if (asi_eop) begin
                                r_empty <= asi_empty;
                                r_state <= S_HDR;
                            end else if (MAX_PKT_WORDS == 1) begin
                                r_trunc <= 1'b1;
                                r_state <= S_DISCARD;
                            end else begin
                                r_state <= S_DATA;
                            end
                        end else begin
                            r_state <= asi_eop ? S_IDLE : S_DROP;
                        end
                    end
                end
                S_DATA: begin
                    if (w_beat) begin
                        r_addr  <= w_data_addr;
                        r_wdata <= asi_data;
                        r_write <= 1'b1;
                        r_count <= CW'(32'(r_count) + 32'd1);
                        if (asi_eop) begin
                            r_empty <= asi_empty;
                            r_state <= S_HDR;
                        end else if (w_last_beat) begin
                            r_trunc <= 1'b1;
                            r_state <= S_DISCARD;
                        end
                    end
                end
                S_DISCARD: begin
                    if (w_beat && asi_eop) begin
                        r_state <= S_HDR;
                    end
                end
                S_HDR: begin
                    // The header goes out only once the last data write has
                    // cleared, so the slot is always filled after its data.
                    if (!r_hdr_sent && w_wr_free) begin
                        r_addr     <= w_hdr_addr;
                        r_wdata    <= w_hdr_word;
                        r_write    <= 1'b1;
                        r_hdr_sent <= 1'b1;
                    end else if (r_hdr_sent && w_wr_done) begin
                        r_pkt_begin <= w_hdr_addr;
                        r_pkt_end   <= w_last_addr;
                        r_pkt_done  <= 1'b1;
                        r_wptr      <= AW'((32'(r_wptr) + 32'(r_count) + 32'd1) & IDX_MASK);
                        r_state     <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (w_beat && asi_eop) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef INGRESS_DROP_COUNT_EN
    logic        w_drop;
    logic [15:0] r_drop_count;

    assign w_drop = (r_state == S_IDLE) && w_beat && asi_sop && !(enable && w_room);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_count <= 16'd0;
        end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`else
    assign drop_count = 16'd0;
`endif

    assign avm_address   = r_addr;
    assign avm_writedata = r_wdata;
    assign avm_write     = r_write;
    assign pkt_begin     = r_pkt_begin;
    assign pkt_end       = r_pkt_end;
    assign pkt_done      = r_pkt_done;

endmodule

// File: tb/tb_pkt_ingress_wr.sv
// Directed bench for pkt_ingress_wr: stream source, stalling write slave
// with a write log, and hand-computed ring images per scenario.
`timescale 1ns/1ps

module tb_pkt_ingress_wr;

`ifdef INGRESS_DROP_COUNT_EN
    localparam int DC_EN = 1;
`else
    localparam int DC_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        asi_valid;
    logic [31:0] asi_data;
    logic        asi_sop;
    logic        asi_eop;
    logic [1:0]  asi_empty;
    logic        asi_ready;
    logic [31:0] avm_address;
    logic [31:0] avm_writedata;
    logic        avm_write;
    logic        avm_waitrequest;
    logic [31:0] rd_ptr;
    logic [31:0] pkt_begin;
    logic [31:0] pkt_end;
    logic        pkt_done;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    pkt_ingress_wr dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .asi_valid       (asi_valid),
        .asi_data        (asi_data),
        .asi_sop         (asi_sop),
        .asi_eop         (asi_eop),
        .asi_empty       (asi_empty),
        .asi_ready       (asi_ready),
        .avm_address     (avm_address),
        .avm_writedata   (avm_writedata),
        .avm_write       (avm_write),
        .avm_waitrequest (avm_waitrequest),
        .rd_ptr          (rd_ptr),
        .pkt_begin       (pkt_begin),
        .pkt_end         (pkt_end),
        .pkt_done        (pkt_done),
        .drop_count      (drop_count)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Slave model state
    int          stall_n     = 0;
    int          stall_cnt   = 0;
    int          stall_total = 0;
    int          ready_stall = 0;
    int          instab      = 0;
    int          npd         = 0;
    bit          held        = 0;
    logic [31:0] h_addr;
    logic [31:0] h_data;
    logic [31:0] wq_a[$];
    logic [31:0] wq_d[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
        if (idx < wq_a.size()) begin
            chk($sformatf("%s_addr", tag), wq_a[idx], a);
            chk($sformatf("%s_data", tag), wq_d[idx], d);
        end else begin
            chk($sformatf("%s_missing", tag), 32'(wq_a.size()), 32'(idx + 1));
        end
    endtask

    // Write slave: stalls each write stall_n cycles, logs completed writes.
    initial begin
        avm_waitrequest = 1'b0;
        forever begin
            @(negedge clk);
            if (avm_write && !reset) begin
                if (held && (avm_address !== h_addr || avm_writedata !== h_data)) instab++;
                if (stall_cnt < stall_n) begin
                    avm_waitrequest = 1'b1;
                    stall_cnt++;
                    stall_total++;
                    held   = 1;
                    h_addr = avm_address;
                    h_data = avm_writedata;
                end else begin
                    avm_waitrequest = 1'b0;
                    stall_cnt = 0;
                    held      = 0;
                    wq_a.push_back(avm_address);
                    wq_d.push_back(avm_writedata);
                end
            end else begin
                avm_waitrequest = 1'b0;
                stall_cnt = 0;
                held      = 0;
            end
            #1;
            if (avm_waitrequest && asi_ready) ready_stall++;
            if (pkt_done) npd++;
        end
    end

    // Called at a negedge; returns at the following negedge after acceptance.
    task automatic send_beat(input logic [31:0] d, input logic s, input logic e,
                             input logic [1:0] emp, output int waited);
        bit ok = 0;
        int guard = 0;
        asi_valid = 1'b1;
        asi_data  = d;
        asi_sop   = s;
        asi_eop   = e;
        asi_empty = emp;
        while (!ok && guard < 200) begin
            #2;
            if (asi_ready) ok = 1;
            else begin
                guard++;
                @(negedge clk);
            end
        end
        if (!ok) chk("beat_timeout", 32'(guard), 32'd0);
        @(posedge clk);
        @(negedge clk);
        waited = guard;
    endtask

    task automatic send_pkt(input int n, input logic [1:0] emp, input logic [31:0] seed,
                            output int late);
        int w;
        late = 0;
        for (int i = 0; i < n; i++) begin
            send_beat(seed + 32'(i), (i == 0), (i == n - 1), emp, w);
            if (i >= 512) late += w;
        end
        asi_valid = 1'b0;
        asi_sop   = 1'b0;
        asi_eop   = 1'b0;
        asi_empty = 2'd0;
    endtask

    task automatic wait_done(input string tag);
        int start = npd;
        int g = 0;
        while (npd == start && g < 3000) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        chk(tag, 32'(npd - start), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int late;
        int base;
        int wp;
        reset = 1'b1; enable = 1'b1; asi_valid = 1'b0; asi_data = 32'd0;
        asi_sop = 1'b0; asi_eop = 1'b0; asi_empty = 2'd0; rd_ptr = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", asi_ready, 1'b0);
        chk("rst_write", avm_write, 1'b0);
        chk("rst_begin", pkt_begin, 32'd0);
        chk("rst_end", pkt_end, 32'd0);
        chk("rst_done", pkt_done, 1'b0);
        chk("rst_drop", drop_count, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk("ready_after_rst", asi_ready, 1'b1);
        @(negedge clk);

        // A: 3 beats, empty=1, no stalls
        wq_a.delete(); wq_d.delete();
        send_pkt(3, 2'd1, 32'hA000_0000, late);
        wait_done("A_done");
        chk("A_nwr", 32'(wq_a.size()), 32'd4);
        chk_wr("A_d0", 0, 32'h4, 32'hA000_0000);
        chk_wr("A_d1", 1, 32'h8, 32'hA000_0001);
        chk_wr("A_d2", 2, 32'hC, 32'hA000_0002);
        chk_wr("A_hdr", 3, 32'h0, 32'h0000_000B);
        chk("A_begin", pkt_begin, 32'h0);
        chk("A_end", pkt_end, 32'hC);

        // B: same packet, 3 stall cycles on every write
        rd_ptr = 32'd4; stall_n = 3; stall_total = 0; ready_stall = 0; instab = 0;
        wq_a.delete(); wq_d.delete();
        send_pkt(3, 2'd1, 32'hB000_0000, late);
        wait_done("B_done");
        stall_n = 0;
        chk("B_nwr", 32'(wq_a.size()), 32'd4);
        chk_wr("B_d0", 0, 32'h14, 32'hB000_0000);
        chk_wr("B_d1", 1, 32'h18, 32'hB000_0001);
        chk_wr("B_d2", 2, 32'h1C, 32'hB000_0002);
        chk_wr("B_hdr", 3, 32'h10, 32'h0000_000B);
        chk("B_begin", pkt_begin, 32'h10);
        chk("B_end", pkt_end, 32'h1C);
        chk("B_stalls", 32'(stall_total), 32'd12);
        chk("B_stable", 32'(instab), 32'd0);
        chk("B_ready_stall", 32'(ready_stall), 32'd0);

        // Fill the ring up to wptr=4094: seven full-size packets then one of 494 words
        wp = 8;
        for (int k = 0; k < 8; k++) begin
            rd_ptr = 32'(wp);
            wq_a.delete(); wq_d.delete();
            send_pkt((k < 7) ? 512 : 494, 2'd0, 32'h1000_0000 * 32'(k + 1), late);
            wait_done("fill_done");
            chk("fill_begin", pkt_begin, 32'(wp * 4));
            if (k == 0) begin
                chk_wr("fill_hdr_max", 512, 32'h20, 32'h0000_0800);
                chk("fill_end_max", pkt_end, 32'h820);
            end
            wp += (k < 7) ? 513 : 495;
        end

        // C: wrap-around at wptr=4094
        rd_ptr = 32'd4094;
        wq_a.delete(); wq_d.delete();
        send_pkt(4, 2'd0, 32'hC000_0000, late);
        wait_done("C_done");
        chk("C_nwr", 32'(wq_a.size()), 32'd5);
        chk_wr("C_d0", 0, 32'h3FFC, 32'hC000_0000);
        chk_wr("C_d1", 1, 32'h0, 32'hC000_0001);
        chk_wr("C_d2", 2, 32'h4, 32'hC000_0002);
        chk_wr("C_d3", 3, 32'h8, 32'hC000_0003);
        chk_wr("C_hdr", 4, 32'h3FF8, 32'h0000_0010);
        chk("C_begin", pkt_begin, 32'h3FF8);
        chk("C_end", pkt_end, 32'h8);

        // D: wptr=3, rd_ptr=516 -> free=512, packet dropped
        rd_ptr = 32'd516;
        wq_a.delete(); wq_d.delete();
        base = npd;
        send_pkt(3, 2'd0, 32'hD000_0000, late);
        repeat (5) @(negedge clk);
        chk("D_nwr", 32'(wq_a.size()), 32'd0);
        chk("D_nodone", 32'(npd - base), 32'd0);
        chk("D_drop", drop_count, 16'(DC_EN));
        // enable=0 single-beat packet is dropped too
        rd_ptr = 32'd3; enable = 1'b0;
        send_pkt(1, 2'd0, 32'hD100_0000, late);
        enable = 1'b1;
        repeat (5) @(negedge clk);
        chk("D_en_nwr", 32'(wq_a.size()), 32'd0);
        chk("D_en_drop", drop_count, 16'(2 * DC_EN));
        // free=513 accepted: single beat, empty=2
        rd_ptr = 32'd517;
        send_pkt(1, 2'd2, 32'hD200_0000, late);
        wait_done("D_edge_done");
        chk_wr("D_edge_d0", 0, 32'h10, 32'hD200_0000);
        chk_wr("D_edge_hdr", 1, 32'hC, 32'h0000_0002);
        chk("D_edge_end", pkt_end, 32'h10);

        // E: 600-beat packet truncated at 512 words
        rd_ptr = 32'd5;
        wq_a.delete(); wq_d.delete();
        send_pkt(600, 2'd3, 32'hE000_0000, late);
        wait_done("E_done");
        chk("E_nwr", 32'(wq_a.size()), 32'd513);
        chk_wr("E_first", 0, 32'h18, 32'hE000_0000);
        chk_wr("E_last", 511, 32'h814, 32'hE000_01FF);
        chk_wr("E_hdr", 512, 32'h14, 32'h8000_0800);
        chk("E_end", pkt_end, 32'h814);
        chk("E_discard_ready", 32'(late), 32'd0);

        // F: reset on the 2nd beat with the first write stalled
        rd_ptr = 32'd518; stall_n = 3;
        asi_valid = 1'b1; asi_sop = 1'b1; asi_eop = 1'b0; asi_data = 32'hF000_0000;
        @(posedge clk);
        @(negedge clk);
        asi_sop = 1'b0; asi_data = 32'hF000_0001; reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; asi_valid = 1'b0;
        #2;
        chk("F_write_off", avm_write, 1'b0);
        chk("F_ready", asi_ready, 1'b1);
        chk("F_begin", pkt_begin, 32'd0);
        chk("F_end", pkt_end, 32'd0);
        chk("F_drop", drop_count, 16'd0);
        stall_n = 0;
        @(negedge clk);
        rd_ptr = 32'd0;
        wq_a.delete(); wq_d.delete();
        send_pkt(3, 2'd1, 32'h6000_0000, late);
        wait_done("F_done");
        chk("F_nwr", 32'(wq_a.size()), 32'd4);
        chk_wr("F_d0", 0, 32'h4, 32'h6000_0000);
        chk_wr("F_hdr", 3, 32'h0, 32'h0000_000B);
        chk("F_pbegin", pkt_begin, 32'h0);
        chk("F_pend", pkt_end, 32'hC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
